// File: rtl/counter_pkg.sv
// Shared types and helpers for the loadable counter and its load controller.
package counter_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } load_state_t;

  // Terminal count of a w-bit counter, returned in a 32-bit container.
  function automatic logic [31:0] all_ones(input int unsigned w);
    logic [31:0] val;
    if (w >= 32'd32) begin
      val = 32'hFFFF_FFFF;
    end else begin
      val = (32'd1 << w) - 32'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus optional counter debounce for one pushbutton.
// Debounce counter is built only when COUNTER_LOAD_CTRL_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  logic sync1_r;
  logic sync2_r;
  logic stable_r;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  // bring the asynchronous button into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

`ifdef COUNTER_LOAD_CTRL_DEBOUNCE_EN
  localparam int DB_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_CNT_W-1:0] db_cnt_r;

  // accept a new level only after it has persisted DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt_r <= {DB_CNT_W{1'b0}};
      stable_r <= 1'b0;
    end else if (sync2_r == stable_r) begin
      db_cnt_r <= {DB_CNT_W{1'b0}};
    end else if (db_cnt_r == DB_LAST) begin
      db_cnt_r <= {DB_CNT_W{1'b0}};
      stable_r <= ~stable_r;
    end else begin
      db_cnt_r <= db_cnt_r + {{(DB_CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  // no filtering: the synchronized level is simply registered once more
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_r <= 1'b0;
    end else begin
      stable_r <= sync2_r;
    end
  end
`endif

  assign stable = stable_r;

endmodule

// File: rtl/counter_load_ctrl.sv
// Load controller for the 4-bit loadable counter: debounced button press or
// terminal-count wrap produces one load strobe with captured switch data.
// Optional debounce filter: COUNTER_LOAD_CTRL_DEBOUNCE_EN.
module counter_load_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_load_raw,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             reload_en,
  input  logic [WIDTH-1:0] count_in,
  output logic             load,
  output logic [WIDTH-1:0] data,
  output logic             busy
);

  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(all_ones(WIDTH));

  logic             btn_stable_s;
  logic             btn_stable_d_r;
  logic [WIDTH-1:0] count_prev_r;
  logic             press_evt_s;
  logic             wrap_evt_s;
  logic             capture_s;
  load_state_t      state_r;
  load_state_t      state_nxt_s;
  logic             load_r;
  logic             busy_r;
  logic [WIDTH-1:0] data_r;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_load_raw),
    .stable(btn_stable_s)
  );

  // edge-detect history for the button and the counter value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_stable_d_r <= 1'b0;
      count_prev_r   <= {WIDTH{1'b0}};
    end else begin
      btn_stable_d_r <= btn_stable_s;
      count_prev_r   <= count_in;
    end
  end

  // wrap fires only on arrival at terminal, so loading all-ones cannot loop
  assign press_evt_s = btn_stable_s & ~btn_stable_d_r;
  assign wrap_evt_s  = reload_en & (count_in == TERM_VAL) & (count_prev_r != TERM_VAL);

  // next-state decode; a simultaneous press and wrap collapse into one load
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (press_evt_s || wrap_evt_s) begin
          state_nxt_s = LOAD;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (btn_stable_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (!btn_stable_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // state, strobe, busy and captured data; busy tracks state != IDLE exactly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      load_r  <= 1'b0;
      busy_r  <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      load_r  <= (state_r == LOAD);
      busy_r  <= (state_nxt_s != IDLE);
      if (capture_s) begin
        data_r <= sw_data;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign load = load_r;
  assign data = data_r;
  assign busy = busy_r;

endmodule

// File: doc/counter_load_ctrl.md
Name: counter_load_ctrl

Overview:
- Upstream stage for the 4-bit loadable counter. Drives the counter's load and data inputs.
- Turns a raw, bouncy load pushbutton and quasi-static data switches into a clean single-cycle load pulse with stable data.
- Optionally issues an automatic reload when the counter reaches its terminal value.
- Sits between board I/O and the counter, all in the single clk domain.

Parameters:
- WIDTH, 4, data/count width; must match the counter.
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized button level must persist before it is accepted (≥2).
- DB_CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- btn_load_raw  in  1  raw load pushbutton, asynchronous, active-high, bouncy.
- sw_data  in  WIDTH  switch value to load; quasi-static.
- reload_en  in  1  enables auto-reload on counter terminal value; synchronous.
- count_in  in  WIDTH  current counter value, fed back from the counter.
- load  out  1  one-cycle load strobe to the counter.
- data  out  WIDTH  registered load value; held between loads.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, async): load=0, data=0, busy=0, state=IDLE.
  - Sync flops, btn_stable, debounce counter and count_prev all clear to 0.
  - Reset release is synchronous to clk; the first active edge follows deassertion.
- Synchronizer: btn_load_raw passes through a 2-flop synchronizer to give btn_sync.
- Debounce (macro enabled):
  - When btn_sync != btn_stable, db_cnt increments each cycle. When btn_sync == btn_stable, db_cnt clears to 0.
  - When db_cnt reaches DEBOUNCE_CYCLES-1 while still mismatched, btn_stable toggles on that edge and db_cnt clears.
  - Glitches shorter than DEBOUNCE_CYCLES are never accepted.
- press_evt = btn_stable & ~btn_stable_d (one cycle).
- wrap_evt = reload_en & (count_in == all-ones) & (count_prev != all-ones).
  - count_prev is count_in registered each cycle.
  - Fires once per arrival at terminal value; no repeat loop if the loaded data is all ones.
- FSM states: IDLE, LOAD, HOLD.
  - IDLE: on press_evt, capture data<=sw_data and go to LOAD. Else on wrap_evt, capture data<=sw_data and go to LOAD. Else stay. press_evt and wrap_evt in the same cycle produce a single load.
  - LOAD: load=1 for exactly this cycle. Next state is HOLD if btn_stable=1, else IDLE (auto-reload path).
  - HOLD: waits for btn_stable=0, then goes to IDLE. press_evt and wrap_evt are ignored in HOLD, so one press gives one load regardless of hold length.
- Outputs: load is a registered decode of state==LOAD. busy = (state != IDLE). data changes only on capture.
- Latency: raw press stable from edge k gives load=1 in cycle k+2+DEBOUNCE_CYCLES+1. wrap_evt gives load=1 two cycles after count_in reaches all-ones.
- Reset mid-operation: an immediate return to reset values; a pending load is dropped.

Optional Feature:
- Macro: COUNTER_LOAD_CTRL_DEBOUNCE_EN.
- Defined: debounce counter as above.
- Undefined: no db_cnt logic is instantiated. btn_stable = btn_sync registered once. Press-to-load latency becomes 4 cycles and bounces may cause multiple loads.

Decomposition:
- Shared package counter_pkg:
  - WIDTH default constant.
  - State enum load_state_t {IDLE, LOAD, HOLD}.
  - Function all_ones(WIDTH).
- One sub-module: btn_debounce (synchronizer + debounce, ports clk/reset/raw/stable). This is the part reused for future buttons.

Test Plan (DEBOUNCE_CYCLES=4, macro defined unless noted):
- Reset: hold reset=0 with btn high -> load=0, data=0, busy=0. Release -> still 0 until a debounced press arrives.
- Clean press: sw_data=4'b0011, btn_load_raw rises and holds 20 cycles -> exactly one load pulse 7 cycles after the raw rise, data=4'b0011, busy high until 5 cycles after release.
- Bounce: btn toggles every 2 cycles for 12 cycles, then stays low -> no load. With the macro undefined, the same stimulus gives ≥2 loads.
- Auto-reload: reload_en=1, sw_data=4'b0101, count_in steps 1101->1110->1111 and holds 1111 -> one load 2 cycles after 1111 with data=0101; no second load while held.
- Collision: press_evt and wrap_evt in the same IDLE cycle -> single load, next state HOLD.
- Reset mid-op: assert reset during LOAD -> load drops to 0 asynchronously, data=0, and no load after release.
